// File: rtl/sdc_host_arb_if.sv
// Host-side and controller-side request bus seen by the two-port SDRAM host arbiter.
// slave is the arbiter's view; master is the view of the hosts and controller around it.
interface sdc_host_arb_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic              sdr_init_done;

  logic              p0_req;
  logic [ADDR_W-1:0] p0_adr;
  logic [1:0]        p0_len;
  logic              p0_wr_n;
  logic [DATA_W-1:0] p0_wr_data;
  logic [3:0]        p0_wr_en_n;
  logic              p0_ack;
  logic              p0_wr_next;
  logic              p0_rd_valid;

  logic              p1_req;
  logic [ADDR_W-1:0] p1_adr;
  logic [1:0]        p1_len;
  logic              p1_wr_n;
  logic [DATA_W-1:0] p1_wr_data;
  logic [3:0]        p1_wr_en_n;
  logic              p1_ack;
  logic              p1_wr_next;
  logic              p1_rd_valid;

  logic [DATA_W-1:0] p_rd_data;

  logic              sdr_req;
  logic [ADDR_W-1:0] sdr_req_adr;
  logic [1:0]        sdr_req_len;
  logic              sdr_req_wr_n;
  logic [DATA_W-1:0] sdr_wr_data;
  logic [3:0]        sdr_wr_en_n;
  logic              sdr_req_ack;
  logic              sdr_wr_next;
  logic              sdr_rd_valid;
  logic [DATA_W-1:0] sdr_rd_data;

  logic              arb_err;

  modport slave (
    input  sdr_init_done,
    input  p0_req, p0_adr, p0_len, p0_wr_n, p0_wr_data, p0_wr_en_n,
    input  p1_req, p1_adr, p1_len, p1_wr_n, p1_wr_data, p1_wr_en_n,
    output p0_ack, p0_wr_next, p0_rd_valid,
    output p1_ack, p1_wr_next, p1_rd_valid,
    output p_rd_data,
    output sdr_req, sdr_req_adr, sdr_req_len, sdr_req_wr_n, sdr_wr_data, sdr_wr_en_n,
    input  sdr_req_ack, sdr_wr_next, sdr_rd_valid, sdr_rd_data,
    output arb_err
  );

  modport master (
    output sdr_init_done,
    output p0_req, p0_adr, p0_len, p0_wr_n, p0_wr_data, p0_wr_en_n,
    output p1_req, p1_adr, p1_len, p1_wr_n, p1_wr_data, p1_wr_en_n,
    input  p0_ack, p0_wr_next, p0_rd_valid,
    input  p1_ack, p1_wr_next, p1_rd_valid,
    input  p_rd_data,
    input  sdr_req, sdr_req_adr, sdr_req_len, sdr_req_wr_n, sdr_wr_data, sdr_wr_en_n,
    output sdr_req_ack, sdr_wr_next, sdr_rd_valid, sdr_rd_data,
    input  arb_err
  );
endinterface

// File: rtl/sdc_host_arb.sv
// Two-port host arbiter in front of the SDRAM controller, with a read-return FIFO.
// Define SDC_ARB_PRIO_EN for fixed priority (port0 wins); default is round-robin.
module sdc_host_arb #(
  parameter int ADDR_W   = 23,
  parameter int DATA_W   = 32,
  parameter int RQ_DEPTH = 4
) (
  input  logic          mclk,
  input  logic          s_resetn,
  sdc_host_arb_if.slave bus
);
  localparam int PW = $clog2(RQ_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WDATA} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] req_adr;
  logic [1:0]        req_len;
  logic              req_wr_n;
  logic              owner;
  logic [2:0]        wr_cnt;
  logic [2:0]        wr_cnt_nxt;
  logic [2:0]        fifo_mem [RQ_DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     count;
  logic [1:0]        rd_beat;
  logic [2:0]        head;
  logic              ack, push, pop, empty, full, rd_hit, wr_pulse, in_xfer;
  logic              elig0, elig1, winner, grant;
  logic [DATA_W-1:0] wr_data_mux;
  logic              err_q;

  assign in_xfer    = (state == REQ) || (state == WDATA);
  assign ack        = (state == REQ) && bus.sdr_req_ack;
  assign push       = ack && req_wr_n;
  assign empty      = (count == '0);
  assign full       = (count == CW'(RQ_DEPTH));
  assign head       = fifo_mem[rptr];
  assign rd_hit     = bus.sdr_rd_valid && !empty;
  assign pop        = rd_hit && (rd_beat == head[1:0]);
  assign wr_pulse   = in_xfer && bus.sdr_wr_next;
  assign wr_cnt_nxt = wr_cnt + {2'b00, wr_pulse};

`ifndef SDC_ARB_PRIO_EN
  logic rr_ptr;

  always_ff @(posedge mclk or negedge s_resetn) begin
    if (!s_resetn)
      rr_ptr <= 1'b0;
    else if (ack)
      rr_ptr <= ~owner;
  end
`endif

  // A read may only be granted while there is room to track its return beats.
  always_comb begin
    elig0 = bus.p0_req && (!bus.p0_wr_n || !full);
    elig1 = bus.p1_req && (!bus.p1_wr_n || !full);
`ifdef SDC_ARB_PRIO_EN
    winner = !elig0;
`else
    winner = (elig0 && elig1) ? rr_ptr : elig1;
`endif
    grant     = 1'b0;
    state_nxt = state;
    case (state)
      IDLE:    if (bus.sdr_init_done && (elig0 || elig1)) begin
                 grant     = 1'b1;
                 state_nxt = REQ;
               end
      REQ:     if (bus.sdr_req_ack) state_nxt = req_wr_n ? IDLE : WDATA;
      WDATA:   if (wr_cnt_nxt >= ({1'b0, req_len} + 3'd1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge s_resetn) begin
    if (!s_resetn) begin
      state    <= IDLE;
      req_adr  <= '0;
      req_len  <= '0;
      req_wr_n <= 1'b0;
      owner    <= 1'b0;
      wr_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        req_adr  <= winner ? bus.p1_adr  : bus.p0_adr;
        req_len  <= winner ? bus.p1_len  : bus.p0_len;
        req_wr_n <= winner ? bus.p1_wr_n : bus.p0_wr_n;
        owner    <= winner;
        wr_cnt   <= '0;
      end else if (wr_pulse) begin
        wr_cnt <= wr_cnt_nxt;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (push)
      fifo_mem[wptr] <= {owner, req_len};
  end

  // Each entry is popped on its final beat; push and pop together leave count as is.
  always_ff @(posedge mclk or negedge s_resetn) begin
    if (!s_resetn) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      rd_beat <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop)
        rd_beat <= '0;
      else if (rd_hit)
        rd_beat <= rd_beat + 1'b1;
      if (bus.sdr_rd_valid && empty)
        err_q <= 1'b1;
    end
  end

  assign wr_data_mux = owner ? bus.p1_wr_data : bus.p0_wr_data;

  assign bus.sdr_req      = (state == REQ);
  assign bus.sdr_req_adr  = req_adr;
  assign bus.sdr_req_len  = req_len;
  assign bus.sdr_req_wr_n = req_wr_n;
  assign bus.sdr_wr_data  = wr_data_mux;
  assign bus.sdr_wr_en_n  = owner ? bus.p1_wr_en_n : bus.p0_wr_en_n;
  assign bus.p0_ack       = ack && !owner;
  assign bus.p1_ack       = ack && owner;
  assign bus.p0_wr_next   = wr_pulse && !owner;
  assign bus.p1_wr_next   = wr_pulse && owner;
  assign bus.p0_rd_valid  = rd_hit && !head[2];
  assign bus.p1_rd_valid  = rd_hit && head[2];
  assign bus.p_rd_data    = bus.sdr_rd_data;
  assign bus.arb_err      = err_q;
endmodule

// File: tb/tb_sdc_host_arb.sv
// Self-checking bench for sdc_host_arb: arbitration vector table, directed corner
// sequences, then randomized hosts/controller against a transaction-level model.
module tb_sdc_host_arb;
  localparam logic [22:0] A0 = 23'h0000AA;
  localparam logic [22:0] A1 = 23'h400055;

  logic mclk = 1'b0;
  logic s_resetn = 1'b0;
  int   check_count = 0;
  int   pass_count = 0;

  sdc_host_arb_if #(.ADDR_W(23), .DATA_W(32)) bus ();

  sdc_host_arb #(.ADDR_W(23), .DATA_W(32), .RQ_DEPTH(4)) dut (
    .mclk     (mclk),
    .s_resetn (s_resetn),
    .bus      (bus.slave)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    bit          init;
    bit          r0;
    bit          w0n;
    bit          r1;
    bit          w1n;
    bit          exp_req;
    logic [22:0] exp_adr;
    logic [1:0]  exp_len;
    bit          exp_wr_n;
  } vec_t;

  vec_t vecs [6];

  // Host-side request state and the controller-side model for the random phase.
  logic [22:0] h_adr  [2];
  logic [1:0]  h_len  [2];
  logic        h_wr_n [2];
  bit          h_busy [2];
  logic [31:0] wd     [2];
  int          rq_port[$];
  int          rq_beats[$];
  int          rq_ready[$];

  task automatic checkOutput(input string name, input logic act, input logic exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic clear_inputs();
    bus.sdr_init_done = 1'b1;
    bus.p0_req = 1'b0; bus.p0_adr = '0; bus.p0_len = '0; bus.p0_wr_n = 1'b1;
    bus.p0_wr_data = '0; bus.p0_wr_en_n = 4'hF;
    bus.p1_req = 1'b0; bus.p1_adr = '0; bus.p1_len = '0; bus.p1_wr_n = 1'b1;
    bus.p1_wr_data = '0; bus.p1_wr_en_n = 4'hF;
    bus.sdr_req_ack = 1'b0; bus.sdr_wr_next = 1'b0;
    bus.sdr_rd_valid = 1'b0; bus.sdr_rd_data = '0;
  endtask

  task automatic do_reset(input bit chk);
    @(negedge mclk);
    s_resetn = 1'b0;
    clear_inputs();
    #1;
    if (chk) begin
      checkOutput("rst_sdr_req", bus.sdr_req, 1'b0);
      checkWord("rst_sdr_req_adr", 32'(bus.sdr_req_adr), 32'h0);
      checkWord("rst_sdr_req_len", 32'(bus.sdr_req_len), 32'h0);
      checkOutput("rst_sdr_req_wr_n", bus.sdr_req_wr_n, 1'b0);
      checkOutput("rst_p0_ack", bus.p0_ack, 1'b0);
      checkOutput("rst_p1_ack", bus.p1_ack, 1'b0);
      checkOutput("rst_arb_err", bus.arb_err, 1'b0);
    end
    @(negedge mclk);
    s_resetn = 1'b1;
  endtask

  // One grant decision from reset: request fields appear the cycle after IDLE sees them.
  task automatic applyStimulus(input vec_t v);
    do_reset(1'b0);
    bus.sdr_init_done = v.init;
    bus.p0_req = v.r0; bus.p0_adr = A0; bus.p0_len = 2'd2; bus.p0_wr_n = v.w0n;
    bus.p1_req = v.r1; bus.p1_adr = A1; bus.p1_len = 2'd1; bus.p1_wr_n = v.w1n;
    @(negedge mclk);
    #1;
    checkOutput("vec_sdr_req", bus.sdr_req, v.exp_req);
    checkWord("vec_adr", 32'(bus.sdr_req_adr), 32'(v.exp_adr));
    checkWord("vec_len", 32'(bus.sdr_req_len), 32'(v.exp_len));
    checkOutput("vec_wr_n", bus.sdr_req_wr_n, v.exp_wr_n);
    if (v.exp_req) begin
      bus.sdr_req_ack = 1'b1;
      #1;
      checkOutput("vec_p0_ack", bus.p0_ack, v.exp_adr == A0);
      checkOutput("vec_p1_ack", bus.p1_ack, v.exp_adr == A1);
    end
  endtask

  initial begin
    int  e0, e1, win, owner, last, outstanding, free_at, wr_left, ack_cyc;
    bit  busy, req_on, req_next, wr_act, ack, wn, rv;
    int  exp_port;
    logic [31:0] rdata;

    vecs[0] = '{0, 1, 1, 1, 1, 0, 23'h0, 2'd0, 1'b0};
    vecs[1] = '{1, 0, 1, 0, 1, 0, 23'h0, 2'd0, 1'b0};
    vecs[2] = '{1, 1, 1, 0, 1, 1, A0,    2'd2, 1'b1};
    vecs[3] = '{1, 0, 1, 1, 0, 1, A1,    2'd1, 1'b0};
    vecs[4] = '{1, 1, 0, 1, 1, 1, A0,    2'd2, 1'b0};
    vecs[5] = '{1, 1, 1, 1, 0, 1, A0,    2'd2, 1'b1};

    clear_inputs();
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Port0 read of four beats, then a stray beat with nothing outstanding.
    do_reset(1'b1);
    bus.p0_req = 1'b1; bus.p0_adr = 23'h000100; bus.p0_len = 2'd3; bus.p0_wr_n = 1'b1;
    @(negedge mclk); #1;
    checkOutput("a_sdr_req", bus.sdr_req, 1'b1);
    checkWord("a_adr", 32'(bus.sdr_req_adr), 32'h100);
    checkWord("a_len", 32'(bus.sdr_req_len), 32'd3);
    checkOutput("a_wr_n", bus.sdr_req_wr_n, 1'b1);
    @(negedge mclk); #1;
    checkOutput("a_req_held", bus.sdr_req, 1'b1);
    checkOutput("a_no_ack_yet", bus.p0_ack, 1'b0);
    @(negedge mclk); bus.sdr_req_ack = 1'b1; #1;
    checkOutput("a_p0_ack", bus.p0_ack, 1'b1);
    checkOutput("a_p1_ack", bus.p1_ack, 1'b0);
    @(negedge mclk); bus.sdr_req_ack = 1'b0; bus.p0_req = 1'b0; #1;
    checkOutput("a_req_drop", bus.sdr_req, 1'b0);
    checkOutput("a_ack_pulse", bus.p0_ack, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge mclk); bus.sdr_rd_valid = 1'b1; bus.sdr_rd_data = 32'hD000 + 32'(i); #1;
      checkOutput("a_p0_rd_valid", bus.p0_rd_valid, 1'b1);
      checkOutput("a_p1_rd_valid", bus.p1_rd_valid, 1'b0);
      checkWord("a_rd_data", bus.p_rd_data, 32'hD000 + 32'(i));
    end
    @(negedge mclk); bus.sdr_rd_valid = 1'b0; #1;
    checkOutput("a_err_clear", bus.arb_err, 1'b0);
    @(negedge mclk); bus.sdr_rd_valid = 1'b1; #1;
    checkOutput("e_p0_rd_valid", bus.p0_rd_valid, 1'b0);
    checkOutput("e_p1_rd_valid", bus.p1_rd_valid, 1'b0);
    @(negedge mclk); bus.sdr_rd_valid = 1'b0; #1;
    checkOutput("e_err_set", bus.arb_err, 1'b1);
    repeat (3) @(negedge mclk);
    #1;
    checkOutput("e_err_sticky", bus.arb_err, 1'b1);
    do_reset(1'b1);

    // Both ports write two beats in the same cycle; port0 first, data follows owner.
    bus.p0_req = 1'b1; bus.p0_adr = 23'h000200; bus.p0_len = 2'd1; bus.p0_wr_n = 1'b0;
    bus.p0_wr_data = 32'h11111111; bus.p0_wr_en_n = 4'h0;
    bus.p1_req = 1'b1; bus.p1_adr = 23'h400300; bus.p1_len = 2'd1; bus.p1_wr_n = 1'b0;
    bus.p1_wr_data = 32'h22222222; bus.p1_wr_en_n = 4'hA;
    @(negedge mclk); #1;
    checkWord("b_adr0", 32'(bus.sdr_req_adr), 32'h200);
    checkOutput("b_wr_n0", bus.sdr_req_wr_n, 1'b0);
    bus.sdr_req_ack = 1'b1; bus.sdr_wr_next = 1'b1; #1;
    checkOutput("b_p0_ack", bus.p0_ack, 1'b1);
    checkOutput("b_p1_ack", bus.p1_ack, 1'b0);
    checkOutput("b_p0_wr_next", bus.p0_wr_next, 1'b1);
    checkOutput("b_p1_wr_next", bus.p1_wr_next, 1'b0);
    checkWord("b_wr_data0", bus.sdr_wr_data, 32'h11111111);
    @(negedge mclk); bus.sdr_req_ack = 1'b0; bus.p0_req = 1'b0; #1;
    checkOutput("b_p0_wr_next2", bus.p0_wr_next, 1'b1);
    checkWord("b_wr_en0", 32'(bus.sdr_wr_en_n), 32'h0);
    @(negedge mclk); bus.sdr_wr_next = 1'b0; #1;
    checkOutput("b_idle_gap", bus.sdr_req, 1'b0);
    @(negedge mclk); #1;
    checkOutput("b_req1", bus.sdr_req, 1'b1);
    checkWord("b_adr1", 32'(bus.sdr_req_adr), 32'h400300);
    bus.sdr_req_ack = 1'b1; #1;
    checkOutput("b_p1_ack", bus.p1_ack, 1'b1);
    checkOutput("b_p0_ack_off", bus.p0_ack, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge mclk); bus.sdr_req_ack = 1'b0; bus.p1_req = 1'b0; bus.sdr_wr_next = 1'b1; #1;
      checkOutput("b_p1_wr_next", bus.p1_wr_next, 1'b1);
      checkOutput("b_p0_wr_next_off", bus.p0_wr_next, 1'b0);
      checkWord("b_wr_data1", bus.sdr_wr_data, 32'h22222222);
      checkWord("b_wr_en1", 32'(bus.sdr_wr_en_n), 32'hA);
    end
    @(negedge mclk); bus.sdr_wr_next = 1'b0;

    // Four single-beat port0 reads fill the FIFO; a port1 read must wait for a pop.
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) begin
      bus.p0_req = 1'b1; bus.p0_adr = 23'(k); bus.p0_len = 2'd0; bus.p0_wr_n = 1'b1;
      @(negedge mclk); bus.sdr_req_ack = 1'b1; #1;
      checkOutput("c_fill_ack", bus.p0_ack, 1'b1);
      @(negedge mclk); bus.sdr_req_ack = 1'b0; bus.p0_req = 1'b0;
    end
    bus.p1_req = 1'b1; bus.p1_adr = 23'h400077; bus.p1_len = 2'd0; bus.p1_wr_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("c_full_blocks", bus.sdr_req, 1'b0);
      @(negedge mclk);
    end
    bus.sdr_rd_valid = 1'b1; #1;
    checkOutput("c_pop_p0", bus.p0_rd_valid, 1'b1);
    @(negedge mclk); bus.sdr_rd_valid = 1'b0; #1;
    checkOutput("c_decide", bus.sdr_req, 1'b0);
    @(negedge mclk); #1;
    checkOutput("c_p1_granted", bus.sdr_req, 1'b1);
    checkWord("c_p1_adr", 32'(bus.sdr_req_adr), 32'h400077);
    bus.sdr_req_ack = 1'b1; #1;
    checkOutput("c_p1_ack", bus.p1_ack, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge mclk); bus.sdr_req_ack = 1'b0; bus.p1_req = 1'b0; bus.sdr_rd_valid = 1'b1; #1;
      checkOutput("c_drain_p0", bus.p0_rd_valid, i < 3);
      checkOutput("c_drain_p1", bus.p1_rd_valid, i == 3);
    end
    @(negedge mclk); bus.sdr_rd_valid = 1'b0;

    // Head's last beat lands in the same cycle as a new read ack.
    do_reset(1'b0);
    bus.p0_req = 1'b1; bus.p0_adr = 23'h000010; bus.p0_len = 2'd1; bus.p0_wr_n = 1'b1;
    @(negedge mclk); bus.sdr_req_ack = 1'b1;
    @(negedge mclk); bus.sdr_req_ack = 1'b0; bus.p0_req = 1'b0;
    bus.p1_req = 1'b1; bus.p1_adr = 23'h400020; bus.p1_len = 2'd0; bus.p1_wr_n = 1'b1;
    bus.sdr_rd_valid = 1'b1; #1;
    checkOutput("d_beat1_p0", bus.p0_rd_valid, 1'b1);
    @(negedge mclk); bus.sdr_req_ack = 1'b1; #1;
    checkWord("d_p1_adr", 32'(bus.sdr_req_adr), 32'h400020);
    checkOutput("d_p1_ack", bus.p1_ack, 1'b1);
    checkOutput("d_beat2_p0", bus.p0_rd_valid, 1'b1);
    checkOutput("d_beat2_not_p1", bus.p1_rd_valid, 1'b0);
    @(negedge mclk); bus.sdr_req_ack = 1'b0; bus.p1_req = 1'b0; #1;
    checkOutput("d_new_head_p1", bus.p1_rd_valid, 1'b1);
    checkOutput("d_new_head_not_p0", bus.p0_rd_valid, 1'b0);
    @(negedge mclk); bus.sdr_rd_valid = 1'b0; #1;
    checkOutput("d_no_err", bus.arb_err, 1'b0);
    @(negedge mclk); bus.sdr_rd_valid = 1'b1; #1;
    checkOutput("d_empty_drop", bus.p1_rd_valid, 1'b0);
    @(negedge mclk); bus.sdr_rd_valid = 1'b0; #1;
    checkOutput("d_err_after_drain", bus.arb_err, 1'b1);

    // Randomized hosts and controller against a transaction-level model.
    do_reset(1'b0);
    h_busy[0] = 0; h_busy[1] = 0;
    busy = 0; req_on = 0; req_next = 0; wr_act = 0;
    owner = 0; last = 1; outstanding = 0; free_at = 0; wr_left = 0; ack_cyc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (req_next) begin req_on = 1; req_next = 0; end
      for (int p = 0; p < 2; p++) begin
        if (!h_busy[p] && $urandom_range(0, 2) == 0) begin
          h_busy[p] = 1;
          h_wr_n[p] = 1'($urandom);
          h_len[p]  = 2'($urandom);
          h_adr[p]  = {1'(p), 22'($urandom)};
        end
        wd[p] = $urandom;
      end
      bus.p0_req = h_busy[0]; bus.p0_adr = h_adr[0]; bus.p0_len = h_len[0]; bus.p0_wr_n = h_wr_n[0];
      bus.p1_req = h_busy[1]; bus.p1_adr = h_adr[1]; bus.p1_len = h_len[1]; bus.p1_wr_n = h_wr_n[1];
      bus.p0_wr_data = wd[0]; bus.p1_wr_data = wd[1];
      bus.p0_wr_en_n = 4'($urandom); bus.p1_wr_en_n = 4'($urandom);

      if (!busy && cyc >= free_at) begin
        e0 = (h_busy[0] && (!h_wr_n[0] || outstanding < 4)) ? 1 : 0;
        e1 = (h_busy[1] && (!h_wr_n[1] || outstanding < 4)) ? 1 : 0;
        if (e0 + e1 > 0) begin
`ifdef SDC_ARB_PRIO_EN
          win = (e0 == 1) ? 0 : 1;
`else
          win = (e0 + e1 == 2) ? 1 - last : ((e0 == 1) ? 0 : 1);
`endif
          owner = win; busy = 1; req_next = 1;
        end
      end

      ack = req_on && ($urandom_range(0, 1) == 1);
      if (ack && !h_wr_n[owner]) begin
        wr_act = 1; wr_left = int'(h_len[owner]) + 1; ack_cyc = cyc;
      end
      wn = wr_act && wr_left > 0 && ($urandom_range(0, 1) == 1);
      rv = 0; exp_port = 0;
      if (rq_port.size() > 0 && rq_ready[0] <= cyc && $urandom_range(0, 1) == 1) begin
        rv = 1; exp_port = rq_port[0];
      end
      rdata = $urandom;
      bus.sdr_req_ack = ack; bus.sdr_wr_next = wn;
      bus.sdr_rd_valid = rv; bus.sdr_rd_data = rdata;
      #1;
      checkOutput("r_sdr_req", bus.sdr_req, req_on);
      if (req_on) begin
        checkWord("r_adr", 32'(bus.sdr_req_adr), 32'(h_adr[owner]));
        checkWord("r_len", 32'(bus.sdr_req_len), 32'(h_len[owner]));
        checkOutput("r_wr_n", bus.sdr_req_wr_n, h_wr_n[owner]);
      end
      checkOutput("r_p0_ack", bus.p0_ack, ack && owner == 0);
      checkOutput("r_p1_ack", bus.p1_ack, ack && owner == 1);
      checkOutput("r_p0_wr_next", bus.p0_wr_next, wn && owner == 0);
      checkOutput("r_p1_wr_next", bus.p1_wr_next, wn && owner == 1);
      if (wn) checkWord("r_wr_data", bus.sdr_wr_data, wd[owner]);
      checkOutput("r_p0_rd_valid", bus.p0_rd_valid, rv && exp_port == 0);
      checkOutput("r_p1_rd_valid", bus.p1_rd_valid, rv && exp_port == 1);
      if (rv) checkWord("r_rd_data", bus.p_rd_data, rdata);
      checkOutput("r_arb_err", bus.arb_err, 1'b0);

      if (ack) begin
        h_busy[owner] = 0; last = owner; req_on = 0;
        if (h_wr_n[owner]) begin
          outstanding++;
          rq_port.push_back(owner);
          rq_beats.push_back(int'(h_len[owner]) + 1);
          rq_ready.push_back(cyc + 1);
          busy = 0; free_at = cyc + 1;
        end
      end
      if (wn) begin
        wr_left--;
        if (wr_left == 0) begin
          wr_act = 0; busy = 0;
          free_at = (ack_cyc + 2 > cyc + 1) ? ack_cyc + 2 : cyc + 1;
        end
      end
      if (rv) begin
        rq_beats[0] = rq_beats[0] - 1;
        if (rq_beats[0] == 0) begin
          void'(rq_port.pop_front()); void'(rq_beats.pop_front()); void'(rq_ready.pop_front());
          outstanding--;
        end
      end
      @(negedge mclk);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
